// File: rtl/adxl362_reader.sv
// ADXL362 SPI reader: powers up the sensor, writes FILTER_CTL and POWER_CTL, then reads axis bursts.
// Define ADXL362_TEMP_EN to extend the burst through TEMP_H and expose temp_raw.
module adxl362_reader #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned NUM_AXES    = 3,
    parameter logic [1:0]  RANGE       = 2'b00,
    parameter int unsigned PWRUP_TICKS = 24000,
    parameter int unsigned IFG_TICKS   = 40000
) (
    input  logic                    iclk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    miso,
    output logic                    sclk,
    output logic                    mosi,
    output logic                    cs,
    output logic [16*NUM_AXES-1:0]  axis_data,
    output logic                    data_valid,
    output logic                    init_done,
    output logic                    busy
`ifdef ADXL362_TEMP_EN
    ,
    output logic [15:0]             temp_raw
`endif
);

`ifdef ADXL362_TEMP_EN
    localparam int unsigned NBYTES = 8;
`else
    localparam int unsigned NBYTES = 2 * NUM_AXES;
`endif
    localparam int unsigned SHW        = 8 * NBYTES;
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_TICKS - 1);
    localparam logic [31:0] IFG_LAST   = 32'(IFG_TICKS - 1);
    localparam logic [31:0] GAP_LAST   = 32'(2 * CLK_DIV - 1);
    localparam logic [3:0]  LAST_BYTE  = 4'(NBYTES - 1);
    localparam logic [7:0]  CMD_WR     = 8'h0A;
    localparam logic [7:0]  CMD_RD     = 8'h0B;
    localparam logic [7:0]  FILT_VAL   = {RANGE, 6'b010011};

    if (NUM_AXES < 1 || NUM_AXES > 3) begin : g_axes_check
        $error("adxl362_reader: NUM_AXES must be in 1..3");
    end
    if (CLK_DIV < 1) begin : g_div_check
        $error("adxl362_reader: CLK_DIV must be >= 1");
    end
`ifdef ADXL362_TEMP_EN
    if (NUM_AXES != 3) begin : g_temp_check
        $error("adxl362_reader: ADXL362_TEMP_EN requires NUM_AXES == 3");
    end
`endif

    typedef enum logic [3:0] {
        PWRUP, WR_FILT, GAP, WR_PWR, INIT_END, IFG, RD_CMD, RD_ADDR, RD_DATA, RD_END
    } state_t;

    state_t             state;
    logic [31:0]        cnt;
    logic [15:0]        div_cnt;
    logic [2:0]         bit_cnt;
    logic [3:0]         byte_cnt;
    logic [7:0]         tx_sr;
    logic [SHW-1:0]     shadow;
    logic               commit_pend;

    logic               byte_last;
    logic [7:0]         next_byte;
    logic [16*NUM_AXES-1:0] axis_next;
`ifdef ADXL362_TEMP_EN
    logic [15:0]        temp_next;
`endif

    assign busy = ~cs;

    // Byte sequencing per transfer state: what follows the current byte, and whether it ends the frame.
    always_comb begin
        byte_last = 1'b0;
        next_byte = '0;
        case (state)
            WR_FILT: begin
                byte_last = (byte_cnt == 4'd2);
                next_byte = (byte_cnt == 4'd0) ? 8'h2C : FILT_VAL;
            end
            WR_PWR: begin
                byte_last = (byte_cnt == 4'd2);
                next_byte = (byte_cnt == 4'd0) ? 8'h2D : 8'h02;
            end
            RD_CMD:  next_byte = 8'h0E;
            RD_ADDR: next_byte = 8'h00;
            RD_DATA: byte_last = (byte_cnt == LAST_BYTE);
            default: ;
        endcase
    end

    // Shadow holds bytes in arrival order (first byte at the top); regroup into {H,L} words.
    always_comb begin
        axis_next = '0;
        for (int unsigned a = 0; a < NUM_AXES; a++) begin
            axis_next[16*a +: 16] = {shadow[SHW-1-8*(2*a+1) -: 8], shadow[SHW-1-8*(2*a) -: 8]};
        end
    end

`ifdef ADXL362_TEMP_EN
    assign temp_next = {shadow[7:0], shadow[15:8]};
`endif

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PWRUP;
            cnt         <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            tx_sr       <= '0;
            shadow      <= '0;
            commit_pend <= 1'b0;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            cs          <= 1'b1;
            axis_data   <= '0;
            data_valid  <= 1'b0;
            init_done   <= 1'b0;
`ifdef ADXL362_TEMP_EN
            temp_raw    <= '0;
`endif
        end else begin
            data_valid  <= commit_pend;
            commit_pend <= 1'b0;
            if (commit_pend) begin
                axis_data <= axis_next;
`ifdef ADXL362_TEMP_EN
                temp_raw  <= temp_next;
`endif
            end

            case (state)
                PWRUP: begin
                    if (cnt == PWRUP_LAST) begin
                        cnt      <= '0;
                        state    <= WR_FILT;
                        cs       <= 1'b0;
                        tx_sr    <= CMD_WR;
                        mosi     <= CMD_WR[7];
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        state    <= WR_PWR;
                        cs       <= 1'b0;
                        tx_sr    <= CMD_WR;
                        mosi     <= CMD_WR[7];
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                INIT_END: begin
                    init_done <= 1'b1;
                    cnt       <= '0;
                    state     <= IFG;
                end

                IFG: begin
                    if (cnt != IFG_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (en) begin
                        state    <= RD_CMD;
                        cs       <= 1'b0;
                        tx_sr    <= CMD_RD;
                        mosi     <= CMD_RD[7];
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end

                RD_END: begin
                    cs    <= 1'b1;
                    cnt   <= '0;
                    state <= IFG;
                end

                WR_FILT, WR_PWR, RD_CMD, RD_ADDR, RD_DATA: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                            if (state == RD_DATA) begin
                                shadow <= {shadow[SHW-2:0], miso};
                                if (bit_cnt == 3'd7 && byte_last) begin
                                    commit_pend <= 1'b1;
                                end
                            end
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx_sr   <= {tx_sr[6:0], 1'b0};
                                mosi    <= tx_sr[6];
                            end else begin
                                bit_cnt <= '0;
                                if (byte_last) begin
                                    mosi <= 1'b0;
                                    case (state)
                                        WR_FILT: begin
                                            cs    <= 1'b1;
                                            cnt   <= '0;
                                            state <= GAP;
                                        end
                                        WR_PWR: begin
                                            cs    <= 1'b1;
                                            state <= INIT_END;
                                        end
                                        default: state <= RD_END;
                                    endcase
                                end else begin
                                    tx_sr <= next_byte;
                                    mosi  <= next_byte[7];
                                    case (state)
                                        RD_CMD:  state <= RD_ADDR;
                                        RD_ADDR: begin
                                            state    <= RD_DATA;
                                            byte_cnt <= '0;
                                        end
                                        default: byte_cnt <= byte_cnt + 1'b1;
                                    endcase
                                end
                            end
                        end
                    end
                end

                default: state <= PWRUP;
            endcase
        end
    end

endmodule
